// File: rtl/fxp32s_normalizer_pkg.sv
// Shared constants for the fxp32 sign-magnitude normalisation path.
// The float packer imports the same package.
package fxp32s_normalizer_pkg;

   localparam int FXP32_WIDTH     = 32;
   localparam int FXP32_LZC_W     = 6;
   localparam int FXP32_FRAC_BITS = 16;
   localparam int FXP32_EXP_W     = 7;

endpackage

// File: rtl/fxp32s_normalizer_lzc.sv
// Combinational leading-zero counter for a 32-bit word, built as a 2/4/8/16/32 merge tree.
// count saturates at 32 for an all-zero word; all_zero flags that case.
module fxp32s_normalizer_lzc
   import fxp32s_normalizer_pkg::*;
(
   input  logic [FXP32_WIDTH-1:0] mag,
   output logic [FXP32_LZC_W-1:0] count,
   output logic                   all_zero
);

   logic [15:0] z1_s;
   logic [15:0] c1_s;
   logic [7:0]  z2_s;
   logic [1:0]  c2_s [8];
   logic [3:0]  z3_s;
   logic [2:0]  c3_s [4];
   logic [1:0]  z4_s;
   logic [3:0]  c4_s [2];
   logic        z5_s;
   logic [4:0]  c5_s;

   // Each merge: if the upper half is empty, count = half width + lower count.
   for (genvar i = 0; i < 16; i++) begin : g_l1
      assign z1_s[i] = ~(mag[2*i+1] | mag[2*i]);
      assign c1_s[i] = ~mag[2*i+1];
   end

   for (genvar i = 0; i < 8; i++) begin : g_l2
      assign z2_s[i] = z1_s[2*i+1] & z1_s[2*i];
      assign c2_s[i] = z1_s[2*i+1] ? {1'b1, c1_s[2*i]} : {1'b0, c1_s[2*i+1]};
   end

   for (genvar i = 0; i < 4; i++) begin : g_l3
      assign z3_s[i] = z2_s[2*i+1] & z2_s[2*i];
      assign c3_s[i] = z2_s[2*i+1] ? {1'b1, c2_s[2*i]} : {1'b0, c2_s[2*i+1]};
   end

   for (genvar i = 0; i < 2; i++) begin : g_l4
      assign z4_s[i] = z3_s[2*i+1] & z3_s[2*i];
      assign c4_s[i] = z3_s[2*i+1] ? {1'b1, c3_s[2*i]} : {1'b0, c3_s[2*i+1]};
   end

   assign z5_s     = z4_s[1] & z4_s[0];
   assign c5_s     = z4_s[1] ? {1'b1, c4_s[0]} : {1'b0, c4_s[1]};
   assign all_zero = z5_s;
   assign count    = z5_s ? 6'd32 : {1'b0, c5_s};

endmodule

// File: rtl/fxp32s_normalizer.sv
// Two-stage valid/ready normaliser: S1 captures the word with its leading-zero count,
// S2 left-justifies the magnitude and derives the signed exponent.
module fxp32s_normalizer
   import fxp32s_normalizer_pkg::*;
#(
   parameter int WIDTH     = FXP32_WIDTH,
   parameter int LZC_W     = FXP32_LZC_W,
   parameter int FRAC_BITS = FXP32_FRAC_BITS,
   parameter int EXP_W     = FXP32_EXP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [WIDTH-1:0] in_mag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [WIDTH-1:0] out_mant,
   output logic [LZC_W-1:0] out_lzc,
   output logic [EXP_W-1:0] out_exp,
   output logic             out_zero
);

   localparam logic [EXP_W-1:0] EXP_OFFSET = EXP_W'(WIDTH - 1 - FRAC_BITS);

   logic             v1_r;
   logic             v2_r;
   logic             rdy1_s;
   logic             rdy2_s;
   logic             sign1_r;
   logic [WIDTH-1:0] mag1_r;
   logic [LZC_W-1:0] lzc1_r;
   logic             zero1_r;
   logic [LZC_W-1:0] lzc_s;
   logic             zero_s;
   logic [WIDTH-1:0] sh0_s;
   logic [WIDTH-1:0] sh1_s;
   logic [WIDTH-1:0] sh2_s;
   logic [WIDTH-1:0] sh3_s;
   logic [WIDTH-1:0] sh4_s;
   logic [EXP_W-1:0] exp_s;

   fxp32s_normalizer_lzc u_lzc (
      .mag      (in_mag),
      .count    (lzc_s),
      .all_zero (zero_s)
   );

   assign rdy2_s    = ~v2_r | out_ready;
   assign rdy1_s    = ~v1_r | rdy2_s;
   assign in_ready  = rdy1_s;
   assign out_valid = v2_r;

   // A zero magnitude shifts to zero regardless of lzc bit 5, so five stages suffice.
   assign sh0_s = lzc1_r[0] ? {mag1_r[WIDTH-2:0], 1'b0}     : mag1_r;
   assign sh1_s = lzc1_r[1] ? {sh0_s[WIDTH-3:0], 2'b00}     : sh0_s;
   assign sh2_s = lzc1_r[2] ? {sh1_s[WIDTH-5:0], 4'h0}      : sh1_s;
   assign sh3_s = lzc1_r[3] ? {sh2_s[WIDTH-9:0], 8'h00}     : sh2_s;
   assign sh4_s = lzc1_r[4] ? {sh3_s[WIDTH-17:0], 16'h0000} : sh3_s;

   // Exponent in EXP_W-bit two's complement; zero words report exponent 0.
   always_comb begin
      exp_s = {EXP_W{1'b0}};
      if (zero1_r) begin
         exp_s = {EXP_W{1'b0}};
      end else begin
         exp_s = EXP_OFFSET - EXP_W'(lzc1_r);
      end
   end

   // Stage 1: valid flag plus captured operand and its leading-zero count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_r    <= 1'b0;
         sign1_r <= 1'b0;
         mag1_r  <= {WIDTH{1'b0}};
         lzc1_r  <= {LZC_W{1'b0}};
         zero1_r <= 1'b0;
      end else if (rdy1_s) begin
         v1_r <= in_valid;
         if (in_valid) begin
            sign1_r <= in_sign;
            mag1_r  <= in_mag;
            lzc1_r  <= lzc_s;
            zero1_r <= zero_s;
         end
      end
   end

   // Stage 2: registered outputs; held while the downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_r     <= 1'b0;
         out_sign <= 1'b0;
         out_mant <= {WIDTH{1'b0}};
         out_lzc  <= {LZC_W{1'b0}};
         out_exp  <= {EXP_W{1'b0}};
         out_zero <= 1'b0;
      end else if (rdy2_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            out_sign <= sign1_r & ~zero1_r;
            out_mant <= sh4_s;
            out_lzc  <= lzc1_r;
            out_exp  <= exp_s;
            out_zero <= zero1_r;
         end
      end
   end

endmodule

// File: tb/tb_fxp32s_normalizer.sv
// Directed self-checking bench for fxp32s_normalizer: single words, streaming,
// back-pressure and asynchronous reset with a full pipeline.
module tb_fxp32s_normalizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [31:0] in_mag;
   logic        out_valid;
   logic        out_ready;
   logic        out_sign;
   logic [31:0] out_mant;
   logic [5:0]  out_lzc;
   logic [6:0]  out_exp;
   logic        out_zero;

   int total = 0;
   int bad   = 0;
   int idx   = 0;
   int n_acc = 0;
   int n_out = 0;
   logic [46:0] sb [$];
   logic [31:0] words [12] = '{32'h0000_0001, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF,
                               32'h0000_8000, 32'h8000_0000, 32'h0000_FFFF, 32'h0040_0000,
                               32'h0000_0003, 32'h7FFF_FFFF, 32'h0001_0001, 32'h0F00_0000};

   fxp32s_normalizer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_mag    (in_mag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_mant  (out_mant),
      .out_lzc   (out_lzc),
      .out_exp   (out_exp),
      .out_zero  (out_zero)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [46:0] obs_word();
      return {out_sign, out_mant, out_lzc, out_exp, out_zero};
   endfunction

   function automatic logic [46:0] model(input logic s, input logic [31:0] m);
      int lz;
      logic [31:0] mant;
      logic [6:0]  e;
      lz = 32;
      for (int i = 0; i < 32; i++) begin
         if (m[i]) lz = 31 - i;
      end
      mant = m << lz;
      e    = (m == 32'd0) ? 7'd0 : 7'(15 - lz);
      return {s & (m != 32'd0), mant, 6'(lz), e, (m == 32'd0)};
   endfunction

   task automatic do_cycle(input logic iv, input logic ordy, output logic acc, output logic xfer,
                           output logic rdy);
      @(negedge clk);
      in_valid = iv && (idx < 12);
      in_sign  = idx[0];
      if (idx < 12) in_mag = words[idx];
      else          in_mag = 32'hDEAD_BEEF;
      out_ready = ordy;
      #1;
      rdy  = in_ready;
      xfer = out_valid && out_ready;
      acc  = in_valid && in_ready;
      if (xfer) begin
         n_out++;
         check_value("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            check_value("stream_word", 64'(obs_word()), 64'(sb[0]));
            sb.delete(0);
         end
      end
      if (acc) begin
         sb.push_back(model(in_sign, in_mag));
         idx++;
         n_acc++;
      end
   endtask

   task automatic send_one(input logic sg, input logic [31:0] mg);
      @(negedge clk);
      in_valid  = 1'b1;
      in_sign   = sg;
      in_mag    = mg;
      out_ready = 1'b1;
      #1;
      check_value("acc_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_mag   = 32'hDEAD_BEEF;
      #1;
      check_value("lat1_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      check_value("lat2_valid", 64'(out_valid), 64'd1);
   endtask

   initial begin
      logic        acc;
      logic        xfer;
      logic        rdy;
      logic [46:0] held;
      int          first_out;
      int          last_out;
      int          acc_b;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_mag    = 32'd0;
      out_ready = 1'b0;
      #12;
      check_value("rst_out_valid", 64'(out_valid), 64'd0);
      check_value("rst_outputs", 64'(obs_word()), 64'd0);
      check_value("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      send_one(1'b0, 32'h0001_0000);
      check_value("t1_lzc", 64'(out_lzc), 64'd15);
      check_value("t1_mant", 64'(out_mant), 64'h8000_0000);
      check_value("t1_exp", 64'(out_exp), 64'h00);
      check_value("t1_zero", 64'(out_zero), 64'd0);
      check_value("t1_sign", 64'(out_sign), 64'd0);

      send_one(1'b1, 32'h8000_0000);
      check_value("t2_lzc", 64'(out_lzc), 64'd0);
      check_value("t2_mant", 64'(out_mant), 64'h8000_0000);
      check_value("t2_exp", 64'(out_exp), 64'h0F);
      check_value("t2_sign", 64'(out_sign), 64'd1);

      send_one(1'b1, 32'h0000_0000);
      check_value("t3_zero", 64'(out_zero), 64'd1);
      check_value("t3_sign", 64'(out_sign), 64'd0);
      check_value("t3_lzc", 64'(out_lzc), 64'd32);
      check_value("t3_mant", 64'(out_mant), 64'h0);
      check_value("t3_exp", 64'(out_exp), 64'h00);

      send_one(1'b0, 32'h0000_0001);
      check_value("t4_lzc", 64'(out_lzc), 64'd31);
      check_value("t4_mant", 64'(out_mant), 64'h8000_0000);
      check_value("t4_exp", 64'(out_exp), 64'h70);
      check_value("t4_zero", 64'(out_zero), 64'd0);

      // Phase A: eight back-to-back words with an always-ready sink.
      @(negedge clk);
      first_out = -1;
      last_out  = -1;
      for (int c = 0; c < 10; c++) begin
         do_cycle(c < 8, 1'b1, acc, xfer, rdy);
         if (xfer) begin
            if (first_out < 0) first_out = c;
            last_out = c;
         end
      end
      check_value("a_accepts", 64'(n_acc), 64'd8);
      check_value("a_outputs", 64'(n_out), 64'd8);
      check_value("a_first_out", 64'(first_out), 64'd2);
      check_value("a_consecutive", 64'(last_out - first_out), 64'd7);

      // Phase B: stall the sink for four cycles.
      acc_b = 0;
      held  = 47'd0;
      for (int c = 0; c < 4; c++) begin
         do_cycle(1'b1, 1'b0, acc, xfer, rdy);
         if (acc) acc_b++;
         if (c == 2) begin
            check_value("b_ready_low2", 64'(rdy), 64'd0);
            check_value("b_valid2", 64'(out_valid), 64'd1);
            held = obs_word();
            check_value("b_head_word", 64'(held), 64'(sb[0]));
         end
         if (c == 3) begin
            check_value("b_ready_low3", 64'(rdy), 64'd0);
            check_value("b_hold", 64'(obs_word()), 64'(held));
         end
      end
      check_value("b_accepts", 64'(acc_b), 64'd2);

      do_cycle(1'b1, 1'b1, acc, xfer, rdy);
      check_value("b_simul_ready", 64'(rdy), 64'd1);
      check_value("b_simul_acc", 64'(acc), 64'd1);
      check_value("b_simul_xfer", 64'(xfer), 64'd1);

      for (int c = 0; c < 30; c++) begin
         if (idx == 12 && sb.size() == 0) break;
         do_cycle(1'b1, 1'b1, acc, xfer, rdy);
      end
      check_value("drain_empty", 64'(sb.size()), 64'd0);
      check_value("total_acc", 64'(n_acc), 64'd12);
      check_value("total_out", 64'(n_out), 64'd12);

      // Asynchronous reset with both stages full.
      @(negedge clk);
      in_valid  = 1'b1;
      in_sign   = 1'b1;
      in_mag    = 32'h0000_0F00;
      out_ready = 1'b0;
      @(negedge clk);
      in_mag = 32'h0000_0001;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check_value("pre_rst_valid", 64'(out_valid), 64'd1);
      check_value("pre_rst_ready", 64'(in_ready), 64'd0);
      rst = 1'b1;
      #1;
      check_value("arst_valid", 64'(out_valid), 64'd0);
      check_value("arst_outputs", 64'(obs_word()), 64'd0);
      check_value("arst_ready", 64'(in_ready), 64'd1);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;

      send_one(1'b1, 32'h0000_0100);
      check_value("post_rst_word", 64'(obs_word()), 64'({1'b1, 32'h8000_0000, 6'd23, 7'h78, 1'b0}));
      @(negedge clk);
      #1;
      check_value("post_rst_drained", 64'(out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
